// File: rtl/cmd_input_conditioner.sv
// Run/halt switch front end: synchronise, debounce and edge-detect two raw
// switch inputs into clean clk-domain command pulses and debounced levels.

// One switch channel: 2-FF synchroniser, saturating-free debounce counter and
// debounced level. rise_c flags the edge at which the level is about to go 0->1.
module cmd_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic lvl_o,
  output logic rise_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             lvl_q;
  logic             lvl_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Synchroniser, counter and level registers; reset discards any partial count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  // Debounce: count cycles of disagreement, commit the new level on the last one.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign rise_c = lvl_d & ~lvl_q;
  assign lvl_o  = lvl_q;

endmodule

// Two independent channels plus halt-priority pulse generation.
module cmd_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run_raw,
  input  logic halt_raw,
  output logic run,
  output logic halt,
  output logic run_lvl,
  output logic halt_lvl
);

  logic run_rise_c;
  logic halt_rise_c;
  logic run_q;
  logic run_d;
  logic halt_q;
  logic halt_d;

  cmd_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_run_ch (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (run_raw),
    .lvl_o  (run_lvl),
    .rise_c (run_rise_c)
  );

  cmd_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_halt_ch (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (halt_raw),
    .lvl_o  (halt_lvl),
    .rise_c (halt_rise_c)
  );

  // Pulse selection: a simultaneous run rise is dropped in favour of halt.
  always_comb begin
    halt_d = halt_rise_c;
    run_d  = run_rise_c & ~halt_rise_c;
  end

  // Pulses are registered at the same edge the debounced level rises.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q  <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      halt_q <= halt_d;
    end
  end

  assign run  = run_q;
  assign halt = halt_q;

endmodule

// File: tb/tb_cmd_input_conditioner.sv
// Bench for cmd_input_conditioner: directed switch stimulus pushes expected
// output snapshots (edge number + outputs) into a queue; a negedge monitor pops
// one whenever the DUT outputs change and compares.
module tb_cmd_input_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned LAT = 2 + DEB;

  logic clk = 1'b0;
  logic reset;
  logic run_raw;
  logic halt_raw;
  logic run;
  logic halt;
  logic run_lvl;
  logic halt_lvl;

  typedef struct packed {
    int unsigned edge_n;
    logic [3:0]  outs;   // {run, halt, run_lvl, halt_lvl}
  } exp_t;

  exp_t        exp_q[$];
  int unsigned edge_cnt  = 0;
  logic        rst_smp   = 1'b0;
  logic [3:0]  prev_outs = 4'b0000;
  logic        done      = 1'b0;
  int unsigned total     = 0;
  int unsigned bad       = 0;

  always #5 clk = ~clk;

  cmd_input_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run_raw  (run_raw),
    .halt_raw (halt_raw),
    .run      (run),
    .halt     (halt),
    .run_lvl  (run_lvl),
    .halt_lvl (halt_lvl)
  );

  // Edge counter and the reset value the DUT saw at that edge.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_smp  <= reset;
  end

  task automatic expect_at(input int unsigned e, input logic r, input logic h,
                           input logic rl, input logic hl);
    exp_t x;
    x.edge_n = e;
    x.outs   = {r, h, rl, hl};
    exp_q.push_back(x);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: mutual exclusion, zero outputs under reset, and in-order events.
  always @(negedge clk) begin
    logic [3:0] cur;
    exp_t       e;
    if (edge_cnt != 0 && !done) begin
      cur = {run, halt, run_lvl, halt_lvl};
      total = total + 1;
      if (run && halt) begin
        bad = bad + 1;
        $display("FAIL mutex edge=%0d run=%b halt=%b required not both 1", edge_cnt, run, halt);
      end
      if (!rst_smp) begin
        total = total + 1;
        if (cur != 4'b0000) begin
          bad = bad + 1;
          $display("FAIL reset_zero edge=%0d outs=%b required 0000", edge_cnt, cur);
        end
      end
      if (cur != prev_outs) begin
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_change edge=%0d outs=%b prev=%b required no change",
                   edge_cnt, cur, prev_outs);
        end else begin
          e = exp_q.pop_front();
          if (e.edge_n != edge_cnt || e.outs != cur) begin
            bad = bad + 1;
            $display("FAIL event got edge=%0d outs=%b required edge=%0d outs=%b",
                     edge_cnt, cur, e.edge_n, e.outs);
          end
        end
        prev_outs = cur;
      end
    end
  end

  initial begin
    int unsigned t;
    // 1: reset held with both raws high; outputs stay 0.
    reset    = 1'b0;
    run_raw  = 1'b1;
    halt_raw = 1'b1;
    step(3);
    reset    = 1'b1;
    run_raw  = 1'b0;
    halt_raw = 1'b0;
    step(4);

    // 2: clean run press, one pulse at +LAT.
    t = edge_cnt; run_raw = 1'b1;
    expect_at(t + LAT, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_at(t + LAT + 1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(10);

    // 5: release falls without pulse, re-press gives a second pulse.
    t = edge_cnt; run_raw = 1'b0;
    expect_at(t + LAT, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8);
    t = edge_cnt; run_raw = 1'b1;
    expect_at(t + LAT, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_at(t + LAT + 1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(10);
    t = edge_cnt; run_raw = 1'b0;
    expect_at(t + LAT, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8);

    // 3: excursions of DEB-1 and 1 cycles are rejected.
    run_raw = 1'b1; step(DEB - 1); run_raw = 1'b0; step(8);
    halt_raw = 1'b1; step(1); halt_raw = 1'b0; step(8);

    // Bounce: a low blip restarts the count from the final rise.
    run_raw = 1'b1; step(2); run_raw = 1'b0; step(1);
    t = edge_cnt; run_raw = 1'b1;
    expect_at(t + LAT, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_at(t + LAT + 1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(10);
    t = edge_cnt; run_raw = 1'b0;
    expect_at(t + LAT, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8);

    // 4: simultaneous press, halt wins, both levels rise together.
    t = edge_cnt; run_raw = 1'b1; halt_raw = 1'b1;
    expect_at(t + LAT, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_at(t + LAT + 1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(10);
    t = edge_cnt; run_raw = 1'b0; halt_raw = 1'b0;
    expect_at(t + LAT, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8);

    // Independent channels: halt press, then run press while halt held.
    t = edge_cnt; halt_raw = 1'b1;
    expect_at(t + LAT, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_at(t + LAT + 1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(10);
    t = edge_cnt; run_raw = 1'b1;
    expect_at(t + LAT, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_at(t + LAT + 1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(10);
    t = edge_cnt; run_raw = 1'b0; halt_raw = 1'b0;
    expect_at(t + LAT, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8);

    // 6: reset mid-count, raw held: fresh press counted from reset release.
    run_raw = 1'b1; step(3);
    reset = 1'b0; step(1);
    t = edge_cnt; reset = 1'b1;
    expect_at(t + LAT, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_at(t + LAT + 1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(12);

    // Reset clears a set level.
    t = edge_cnt;
    expect_at(t + 1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; run_raw = 1'b0; step(1);
    reset = 1'b1; step(8);

    step(4);
    done = 1'b1;
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL pending_events count=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d required completion", edge_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
